// File: rtl/prox_event_detector_pkg.sv
// Shared state encodings and default timing constants for the proximity event detector.
// Pure declarations: no latency, no backpressure.
package prox_event_detector_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CONFIRM  = 3'd1,
    ST_NEAR     = 3'd2,
    ST_HELD     = 3'd3,
    ST_COOLDOWN = 3'd4
  } state_t;

  localparam int DEF_TICK_DIV   = 5000;
  localparam int DEF_DEB_TICKS  = 20;
  localparam int DEF_HOLD_TICKS = 10000;
  localparam int DEF_COOL_TICKS = 2000;

  localparam logic [7:0] COUNT_MAX = 8'hFF;

  // Width of a tick counter large enough for the biggest of the three limits.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/prox_event_detector_tick_gen.sv
// Sample-tick prescaler: tick is high for one clk every DIV cycles; clr holds the phase at 0.
// Latency: first tick DIV cycles after reset/clr release; no backpressure (free-running).
module tick_gen
  import prox_event_detector_pkg::*;
#(
  parameter int DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || cnt == W'(DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == W'(DIV - 1)) && !clr;

endmodule

// File: rtl/prox_event_detector.sv
// Debounced proximity detector: approach/hold strobes, presence level and saturating approach count.
// Latency: 2-clk input sync plus tick-quantised debounce; outputs registered; no backpressure.
module prox_event_detector
  import prox_event_detector_pkg::*;
#(
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int DEB_TICKS  = DEF_DEB_TICKS,
  parameter int HOLD_TICKS = DEF_HOLD_TICKS,
  parameter int COOL_TICKS = DEF_COOL_TICKS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       test_enable,
  input  logic       prox_in,
  input  logic       clear_count,
  output logic       near,
  output logic       approach_pulse,
  output logic       hold_pulse,
  output logic [7:0] approach_count
);

  localparam int CW = cnt_width(DEB_TICKS, HOLD_TICKS, COOL_TICKS);

  logic [1:0]    sync;
  logic          prox_s;
  logic          tick;
  state_t        state;
  logic [CW-1:0] deb_cnt;
  logic [CW-1:0] hold_cnt;
  logic [CW-1:0] rel_cnt;
  logic [CW-1:0] cool_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[0], prox_in};
    end
  end

  assign prox_s = sync[1];

  tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (test_enable),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      deb_cnt        <= '0;
      hold_cnt       <= '0;
      rel_cnt        <= '0;
      cool_cnt       <= '0;
      near           <= 1'b0;
      approach_pulse <= 1'b0;
      hold_pulse     <= 1'b0;
    end else begin
      approach_pulse <= 1'b0;
      hold_pulse     <= 1'b0;
      if (test_enable) begin
        state    <= ST_IDLE;
        deb_cnt  <= '0;
        hold_cnt <= '0;
        rel_cnt  <= '0;
        cool_cnt <= '0;
        near     <= 1'b0;
      end else if (tick) begin
        case (state)
          ST_IDLE: begin
            if (prox_s) begin
              state   <= ST_CONFIRM;
              deb_cnt <= CW'(1);
            end
          end
          ST_CONFIRM: begin
            if (!prox_s) begin
              state   <= ST_IDLE;
              deb_cnt <= '0;
            end else if (deb_cnt == CW'(DEB_TICKS - 1)) begin
              state          <= ST_NEAR;
              near           <= 1'b1;
              approach_pulse <= 1'b1;
              deb_cnt        <= '0;
              hold_cnt       <= '0;
              rel_cnt        <= '0;
            end else begin
              deb_cnt <= deb_cnt + 1'b1;
            end
          end
          ST_NEAR, ST_HELD: begin
            if (prox_s) begin
              rel_cnt <= '0;
              // hold_cnt only advances before the hold is flagged, so one presence gives one strobe
              if (state == ST_NEAR) begin
                hold_cnt <= hold_cnt + 1'b1;
                if (hold_cnt == CW'(HOLD_TICKS - 1)) begin
                  state      <= ST_HELD;
                  hold_pulse <= 1'b1;
                end
              end
            end else if (rel_cnt == CW'(DEB_TICKS - 1)) begin
              state    <= ST_COOLDOWN;
              near     <= 1'b0;
              rel_cnt  <= '0;
              hold_cnt <= '0;
            end else begin
              rel_cnt <= rel_cnt + 1'b1;
            end
          end
          ST_COOLDOWN: begin
            if (cool_cnt == CW'(COOL_TICKS - 1)) begin
              state    <= ST_IDLE;
              cool_cnt <= '0;
            end else begin
              cool_cnt <= cool_cnt + 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            near  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Counts the visible strobe, so a clear in the strobe cycle wins over the increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      approach_count <= '0;
    end else if (clear_count) begin
      approach_count <= '0;
    end else if (approach_pulse && approach_count != COUNT_MAX) begin
      approach_count <= approach_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_prox_event_detector.sv
// Directed self-checking bench for prox_event_detector with small timing parameters.
// Edge numbers below count rising clk edges since reset (or test_enable) release; ticks fall on multiples of 4.
module tb_prox_event_detector;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       test_enable = 1'b0;
  logic       prox_in = 1'b0;
  logic       clear_count = 1'b0;
  logic       near;
  logic       approach_pulse;
  logic       hold_pulse;
  logic [7:0] approach_count;

  int total = 0;
  int bad = 0;
  int ec = 0;
  int ap_seen = 0;
  int hold_seen = 0;

  always #5 clk = ~clk;

  prox_event_detector #(
    .TICK_DIV   (4),
    .DEB_TICKS  (3),
    .HOLD_TICKS (8),
    .COOL_TICKS (5)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .test_enable    (test_enable),
    .prox_in        (prox_in),
    .clear_count    (clear_count),
    .near           (near),
    .approach_pulse (approach_pulse),
    .hold_pulse     (hold_pulse),
    .approach_count (approach_count)
  );

  always @(posedge clk) begin
    if (approach_pulse === 1'b1) ap_seen = ap_seen + 1;
    if (hold_pulse === 1'b1) hold_seen = hold_seen + 1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      ec++;
    end
  endtask

  task automatic run_to(input int e);
    if (e > ec) step(e - ec);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    prox_in = 1'b0;
    test_enable = 1'b0;
    clear_count = 1'b0;
    step(3);
    rst = 1'b1;
    ec = 0;
  endtask

  task automatic wait_ap(input int lim, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < lim; k++) begin
      if (approach_pulse === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    prox_in = 1'b1;
    step(3);
    total++; if (near !== 1'b0) begin bad++; $display("FAIL reset_near: got %b want 0", near); end
    total++; if (approach_pulse !== 1'b0) begin bad++; $display("FAIL reset_ap: got %b want 0", approach_pulse); end
    total++; if (hold_pulse !== 1'b0) begin bad++; $display("FAIL reset_hold: got %b want 0", hold_pulse); end
    total++; if (approach_count !== 8'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", approach_count); end
  endtask

  task automatic test_approach();
    int base;
    do_reset();
    prox_in = 1'b1;
    base = ap_seen;
    run_to(11);
    total++; if (approach_pulse !== 1'b0) begin bad++; $display("FAIL ap_early: got %b want 0", approach_pulse); end
    run_to(12);
    total++; if (approach_pulse !== 1'b1) begin bad++; $display("FAIL ap_pulse: got %b want 1", approach_pulse); end
    total++; if (near !== 1'b1) begin bad++; $display("FAIL ap_near: got %b want 1", near); end
    run_to(13);
    total++; if (approach_count !== 8'd1) begin bad++; $display("FAIL ap_count: got %0d want 1", approach_count); end
    run_to(24);
    total++; if (ap_seen - base !== 1) begin bad++; $display("FAIL ap_once: got %0d pulses want 1", ap_seen - base); end
  endtask

  task automatic test_glitch();
    int base;
    do_reset();
    prox_in = 1'b1;
    base = ap_seen;
    run_to(6);
    prox_in = 1'b0;
    run_to(40);
    total++; if (ap_seen - base !== 0) begin bad++; $display("FAIL glitch_pulse: got %0d pulses want 0", ap_seen - base); end
    total++; if (near !== 1'b0) begin bad++; $display("FAIL glitch_near: got %b want 0", near); end
    total++; if (approach_count !== 8'd0) begin bad++; $display("FAIL glitch_count: got %0d want 0", approach_count); end
  endtask

  task automatic test_hold_release();
    int base_a;
    int base_h;
    do_reset();
    prox_in = 1'b1;
    base_a = ap_seen;
    base_h = hold_seen;
    run_to(43);
    total++; if (hold_pulse !== 1'b0) begin bad++; $display("FAIL hold_early: got %b want 0", hold_pulse); end
    run_to(44);
    total++; if (hold_pulse !== 1'b1) begin bad++; $display("FAIL hold_pulse: got %b want 1", hold_pulse); end
    run_to(46);
    prox_in = 1'b0;
    run_to(59);
    total++; if (near !== 1'b1) begin bad++; $display("FAIL rel_near_kept: got %b want 1", near); end
    run_to(60);
    total++; if (near !== 1'b0) begin bad++; $display("FAIL rel_near_fall: got %b want 0", near); end
    prox_in = 1'b1;
    run_to(91);
    total++; if (ap_seen - base_a !== 1) begin bad++; $display("FAIL cool_no_reapproach: got %0d pulses want 1", ap_seen - base_a); end
    total++; if (hold_seen - base_h !== 1) begin bad++; $display("FAIL hold_once: got %0d pulses want 1", hold_seen - base_h); end
    run_to(92);
    total++; if (approach_pulse !== 1'b1) begin bad++; $display("FAIL cool_reapproach: got %b want 1", approach_pulse); end
  endtask

  task automatic test_test_mode();
    int base;
    do_reset();
    prox_in = 1'b1;
    run_to(9);
    test_enable = 1'b1;
    base = ap_seen;
    step(20);
    total++; if (ap_seen - base !== 0) begin bad++; $display("FAIL tm_pulse: got %0d pulses want 0", ap_seen - base); end
    total++; if (near !== 1'b0) begin bad++; $display("FAIL tm_near: got %b want 0", near); end
    test_enable = 1'b0;
    ec = 0;
    run_to(11);
    total++; if (approach_pulse !== 1'b0) begin bad++; $display("FAIL tm_ap_early: got %b want 0", approach_pulse); end
    run_to(12);
    total++; if (approach_pulse !== 1'b1) begin bad++; $display("FAIL tm_ap_pulse: got %b want 1", approach_pulse); end
    run_to(14);
    total++; if (approach_count !== 8'd1) begin bad++; $display("FAIL tm_count: got %0d want 1", approach_count); end
    test_enable = 1'b1;
    clear_count = 1'b1;
    step(1);
    clear_count = 1'b0;
    total++; if (approach_count !== 8'd0) begin bad++; $display("FAIL tm_clear: got %0d want 0", approach_count); end
    total++; if (near !== 1'b0) begin bad++; $display("FAIL tm_near_forced: got %b want 0", near); end
    test_enable = 1'b0;
  endtask

  task automatic test_saturation();
    int base;
    int timeouts;
    bit ok;
    do_reset();
    base = ap_seen;
    timeouts = 0;
    for (int i = 0; i < 260; i++) begin
      prox_in = 1'b1;
      wait_ap(200, ok);
      if (!ok) begin
        timeouts++;
        break;
      end
      prox_in = 1'b0;
      for (int k = 0; k < 100 && near !== 1'b0; k++) step(1);
      if (i == 254) begin
        total++; if (approach_count !== 8'd255) begin bad++; $display("FAIL sat_reach: got %0d want 255", approach_count); end
      end
    end
    step(2);
    total++; if (timeouts !== 0) begin bad++; $display("FAIL sat_timeout: got %0d timeouts want 0", timeouts); end
    total++; if (ap_seen - base !== 260) begin bad++; $display("FAIL sat_pulses: got %0d want 260", ap_seen - base); end
    total++; if (approach_count !== 8'd255) begin bad++; $display("FAIL sat_hold: got %0d want 255", approach_count); end
    prox_in = 1'b1;
    wait_ap(200, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL clr_wait: got %b want 1", ok); end
    clear_count = 1'b1;
    step(1);
    clear_count = 1'b0;
    total++; if (approach_count !== 8'd0) begin bad++; $display("FAIL clr_priority: got %0d want 0", approach_count); end
    step(3);
    total++; if (approach_count !== 8'd0) begin bad++; $display("FAIL clr_stays: got %0d want 0", approach_count); end
    prox_in = 1'b0;
  endtask

  task automatic test_reset_mid();
    int base_a;
    int base_h;
    do_reset();
    prox_in = 1'b1;
    run_to(46);
    total++; if (near !== 1'b1) begin bad++; $display("FAIL mid_held_near: got %b want 1", near); end
    #2;
    rst = 1'b0;
    #1;
    total++; if (near !== 1'b0) begin bad++; $display("FAIL mid_near: got %b want 0", near); end
    total++; if (approach_pulse !== 1'b0) begin bad++; $display("FAIL mid_ap: got %b want 0", approach_pulse); end
    total++; if (hold_pulse !== 1'b0) begin bad++; $display("FAIL mid_hold: got %b want 0", hold_pulse); end
    total++; if (approach_count !== 8'd0) begin bad++; $display("FAIL mid_count: got %0d want 0", approach_count); end
    base_a = ap_seen;
    base_h = hold_seen;
    step(10);
    prox_in = 1'b0;
    rst = 1'b1;
    ec = 0;
    run_to(40);
    total++; if ((ap_seen - base_a) + (hold_seen - base_h) !== 0) begin
      bad++; $display("FAIL mid_no_pulse: got %0d pulses want 0", (ap_seen - base_a) + (hold_seen - base_h));
    end
  endtask

  initial begin
    test_reset();
    test_approach();
    test_glitch();
    test_hold_release();
    test_test_mode();
    test_saturation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prox_event_detector.md
PROX_EVENT_DETECTOR -- requirements
Module: prox_event_detector

Interface
REQ-001 SHALL have parameter TICK_DIV, default 5000, giving clk cycles per sample tick (50 MHz -> 10 kHz).
REQ-002 SHALL have parameter DEB_TICKS, default 20, giving consecutive ticks needed to confirm approach or release.
REQ-003 SHALL have parameter HOLD_TICKS, default 10000, giving near-ticks needed to flag a long hold (1 s).
REQ-004 SHALL have parameter COOL_TICKS, default 2000, giving lockout ticks after a release.
REQ-005 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port test_enable, input, 1 bit: 1 freezes detection (test mode).
REQ-008 SHALL have port prox_in, input, 1 bit: raw proximity level from the IR stage, 1 = object near.
REQ-009 SHALL have port clear_count, input, 1 bit: synchronous clear of approach_count.
REQ-010 SHALL have port near, output, 1 bit: debounced presence level.
REQ-011 SHALL have port approach_pulse, output, 1 bit: one-clk strobe on each confirmed approach.
REQ-012 SHALL have port hold_pulse, output, 1 bit: one-clk strobe when a presence lasts HOLD_TICKS.
REQ-013 SHALL have port approach_count, output, 8 bits: saturating count of confirmed approaches.

Function
REQ-014 SHALL pass prox_in through a 2-flop synchronizer; only the synchronized value is evaluated.
REQ-015 SHALL generate tick, a one-cycle strobe every TICK_DIV clk cycles; the prescaler wraps from TICK_DIV-1 to 0.
REQ-016 SHALL change FSM state and counters only on tick cycles, except for reset, test_enable and clear_count.
REQ-017 SHALL implement FSM states IDLE, CONFIRM, NEAR, HELD and COOLDOWN.
REQ-018 SHALL, in IDLE, go to CONFIRM with deb_cnt=1 on a tick with prox=1.
REQ-019 SHALL, in CONFIRM, return to IDLE on a tick with prox=0, and otherwise increment deb_cnt.
REQ-020 SHALL, in CONFIRM, enter NEAR with approach_pulse=1 on the tick that brings deb_cnt to DEB_TICKS.
REQ-021 SHALL, in NEAR, increment hold_cnt on each prox=1 tick.
REQ-022 SHALL, in NEAR, enter HELD with hold_pulse=1 when hold_cnt reaches HOLD_TICKS.
REQ-023 SHALL, in NEAR and HELD, count consecutive prox=0 ticks in rel_cnt and clear rel_cnt on any prox=1 tick.
REQ-024 SHALL, in NEAR and HELD, go to COOLDOWN when rel_cnt reaches DEB_TICKS.
REQ-025 SHALL, in COOLDOWN, ignore prox, count COOL_TICKS ticks, then go to IDLE.
REQ-026 SHALL register all outputs; the pulses are high exactly one clk cycle, in the cycle after the deciding tick.
REQ-027 SHALL drive near=1 only in NEAR and HELD.
REQ-028 SHALL increment approach_count with each approach_pulse and hold it at 255 (no wrap).
REQ-029 SHALL give clear_count priority when it coincides with an increment, so approach_count becomes 0.
REQ-030 SHALL, while test_enable=1, force IDLE, clear every counter except approach_count, and hold near and both pulses at 0.
REQ-031 SHALL let approach_count still respond to clear_count while test_enable=1.
REQ-032 SHALL restart detection from IDLE when test_enable falls.

Reset
REQ-033 SHALL, on rst=0, immediately set state=IDLE, clear synchronizer, prescaler and all counters, and set near, approach_pulse, hold_pulse and approach_count to 0.
REQ-034 SHALL abort any in-progress operation on reset mid-operation, emitting no pulse.

Structure
REQ-035 SHALL take state encodings and default timing constants from the shared tamagotchi package/include.
REQ-036 SHALL implement the prescaler as sub-module tick_gen (parameter DIV, output tick).

Verification
REQ-037 SHALL use bench parameters TICK_DIV=4, DEB_TICKS=3, HOLD_TICKS=8, COOL_TICKS=5 in all scenarios below.
REQ-038 SHALL cover approach: prox_in=1 held for 4 ticks -> exactly one approach_pulse, near=1, approach_count=1.
REQ-039 SHALL cover glitch rejection: prox_in=1 for 2 ticks, then 0 -> no pulse, near=0, count unchanged.
REQ-040 SHALL cover hold and release: prox_in=1 for 12 ticks, then 0 -> one hold_pulse; near falls 3 ticks after release; no re-approach during the 5-tick cooldown despite re-presence.
REQ-041 SHALL cover saturation and clear: 260 approaches -> count=255; clear_count together with an approach_pulse -> count=0.
REQ-042 SHALL cover test mode: test_enable=1 during CONFIRM -> near and pulses stay 0; after release, prox held 3 ticks -> approach_pulse.
REQ-043 SHALL cover reset: rst=0 asserted while in HELD -> all outputs 0 immediately, asynchronously, with no pulse.
